// File: rtl/instr_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch_if : imem request/response bus and decode-side instr handshake |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus8,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus8,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_target
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch : PC owner, single-outstanding imem fetch, instruction FIFO    |
// | Optional IFETCH_PERF_EN adds perf_fetched / perf_flushed counters.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  instr_fetch_if.master     bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        instr_mem_q [FIFO_DEPTH];
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               head_valid;
  logic               pop;
  logic               flush;
  logic               push;
  logic               gnt;
  logic [31:0]        head_pc;
  logic [31:0]        target_pc;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.instr_ready;
  assign flush      = pop & bus.redirect;
  // A response arriving in the redirect cycle is wrong-path, so it never enters the FIFO
  assign push       = (state_q == ST_WAIT) & bus.imem_rvalid & ~flush;
  assign gnt        = (state_q == ST_FETCH) & bus.imem_gnt;
  assign target_pc  = bus.redirect_target & 32'hFFFF_FFFC;
  assign count_d    = flush ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d    = ST_FETCH;
          fetch_pc_d = target_pc;
        end else if (count_q < DEPTH_C) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (gnt) begin
          state_d    = flush ? ST_DROP : ST_WAIT;
          fetch_pc_d = flush ? target_pc : fetch_pc_q + 32'd4;
        end else if (flush) begin
          fetch_pc_d = target_pc;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          fetch_pc_d = target_pc;
          state_d    = bus.imem_rvalid ? ST_FETCH : ST_DROP;
        end else if (bus.imem_rvalid) begin
          state_d = (count_d < DEPTH_C) ? ST_FETCH : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (flush) begin
          fetch_pc_d = target_pc;
        end
        if (bus.imem_rvalid) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
          wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
          instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
          pc_mem_q[wr_ptr_q]    <= fetch_pc_q - 32'd4;
        end
      end
    end
  end

  assign head_pc          = head_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  // Gated by reset so no request leaks out while the state register is held in FETCH
  assign bus.imem_req     = reset & (state_q == ST_FETCH);
  assign bus.imem_addr    = fetch_pc_q & 32'hFFFF_FFFC;
  assign bus.instr        = head_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign bus.instr_valid  = head_valid;
  assign bus.pc           = head_pc;
  assign bus.pc_plus8     = head_pc + 32'd8;

`ifdef IFETCH_PERF_EN
  logic        discard;
  logic [31:0] fetched_q, flushed_q;

  assign discard = bus.imem_rvalid &
                   ((state_q == ST_DROP) | ((state_q == ST_WAIT) & flush));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(push);
      flushed_q <= flushed_q + (flush ? 32'(count_q) : 32'd0) + 32'(discard);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule
`default_nettype wire
